l1_cache_ctrl_wb: RTL and testbench
===================================

// Module: l1_cache_ctrl_wb
// PURPOSE
//  Parametrised write-back/write-allocate controller FSM for the L1 data cache, sitting between CPU stall logic,
//  tag/data SRAM and external memory. Adds multi-word line bursts, a victim write-back address select,
//  a CPU ready handshake and internal tag compare.
// PARAMETERS
//  TAG_W        22  tag bits stored per line and compared against cpu_tag
//  BLOCK_WORDS  4   words per line = memory beats per refill/write-back (>=1, power of 2)
//  CNT_W        32  width of performance counters (L1_CACHE_PERF_EN only)
//  localparam BEAT_W = (BLOCK_WORDS>1) ? $clog2(BLOCK_WORDS) : 1
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  cpu_req        in   1       access request; held high until cpu_ready
//  cpu_we         in   1       1 = store, 0 = load
//  cpu_tag        in   TAG_W   tag of requested address
//  cpu_ready      out  1       one-cycle pulse: access complete
//  sram_valid     in   1       valid bit of indexed line
//  sram_dirty     in   1       dirty bit of indexed line
//  sram_tag       in   TAG_W   stored tag of indexed line
//  sram_cs        out  1       SRAM enable
//  sram_we        out  1       SRAM write strobe (CPU store or refill beat)
//  sram_fill      out  1       1 = write data from memory (refill), sets valid/tag, clears dirty
//  sram_set_dirty out  1       set dirty bit on store hit
//  beat_idx       out  BEAT_W  word index of current burst beat
//  mem_cs         out  1       memory request
//  mem_we         out  1       1 = write-back beat, 0 = refill beat
//  mem_addr_sel   out  1       1 = victim address {sram_tag,index}, 0 = cpu address
//  mem_ack        in   1       memory beat accepted/returned
//  hit_cnt/miss_cnt/wb_cnt out CNT_W  perf counters (L1_CACHE_PERF_EN only)
// BEHAVIOUR
//  States (2-bit): IDLE, COMPARE, WRITE_BACK, ALLOCATE. State and beat counter registered; all outputs combinational.
//  Reset: state=IDLE, beat=0, counters=0; all outputs 0 while rst high. Reset mid-burst aborts at once:
//   mem_cs drops asynchronously, no partial-line recovery.
//  hit = sram_valid && (sram_tag == cpu_tag).
//  IDLE: sram_cs=cpu_req; cpu_req -> COMPARE next edge.
//  COMPARE: sram_cs=1.
//   - !cpu_req -> IDLE, no outputs.
//   - hit -> cpu_ready=1; if cpu_we then sram_we=1, sram_set_dirty=1; -> IDLE.
//   - miss & valid & dirty -> WRITE_BACK, beat=0.
//   - otherwise miss -> ALLOCATE, beat=0.
//  WRITE_BACK: mem_cs=1, mem_we=1, mem_addr_sel=1. Each mem_ack: beat+1. Ack at beat=BLOCK_WORDS-1 -> ALLOCATE, beat=0.
//  ALLOCATE: mem_cs=1, mem_we=0, mem_addr_sel=0. Each mem_ack: sram_cs=sram_we=sram_fill=1 for beat_idx, beat+1.
//   Ack at last beat -> COMPARE; the re-compare hits and completes the access.
//  beat wraps to 0 on last ack; beat_idx is 0 outside bursts. BLOCK_WORDS=1: single ack per phase.
//  mem_ack outside WRITE_BACK/ALLOCATE is ignored. Stalls (no ack) hold state and beat indefinitely.
//  Latency from cpu_req rise to cpu_ready: hit 2 cycles; clean miss 3+refill cycles; dirty miss adds write-back cycles.
// CONFIGURATION
//  L1_CACHE_PERF_EN defined: hit_cnt +1 per hit completion in COMPARE (first compare only; post-refill compare not
//   counted), miss_cnt +1 per COMPARE->ALLOCATE/WRITE_BACK, wb_cnt +1 per COMPARE->WRITE_BACK.
//   All counters saturate at all-ones and reset to 0.
//  Undefined: counter ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package l1_cache_pkg: state encoding localparams (IDLE=0, COMPARE=1, ALLOCATE=2, WRITE_BACK=3), beat-width function.
//  Sub-module l1_beat_counter (BEAT_W, clear, inc, last flag) shared by the write-back and refill phases.
// TESTING
//  Load hit: valid=1, tags equal, req 1 cycle -> cpu_ready at cycle 2, sram_we=0, no mem_cs.
//  Store hit: cpu_we=1 -> cpu_ready, sram_we=1, sram_set_dirty=1 in the same cycle.
//  Clean miss, BLOCK_WORDS=4, ack every 2 cycles -> 4 refill beats (beat_idx 0..3, sram_fill=1), then COMPARE, cpu_ready.
//  Dirty miss -> 4 beats mem_we=1 with mem_addr_sel=1, then 4 refill beats, cpu_ready; with PERF: miss_cnt=1, wb_cnt=1, hit_cnt=0.
//  rst asserted during refill beat 2 -> all outputs 0 immediately; after release, req -> normal COMPARE.
//  Spurious mem_ack in IDLE/COMPARE -> no state or beat change; BLOCK_WORDS=1 miss completes after 1 ack.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared definitions for the L1 write-back cache controller: state encoding and burst beat width.
package l1_cache_pkg;

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_COMPARE    = 2'd1;
   localparam logic [1:0] S_ALLOCATE   = 2'd2;
   localparam logic [1:0] S_WRITE_BACK = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE       = S_IDLE,
      ST_COMPARE    = S_COMPARE,
      ST_ALLOCATE   = S_ALLOCATE,
      ST_WRITE_BACK = S_WRITE_BACK
   } state_e;

   // A single-word line still needs a 1-bit beat index port.
   function automatic int beat_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/l1_beat_counter.sv
// Burst beat counter shared by the write-back and refill phases; wraps to 0 on the last beat.
module l1_beat_counter #(
   parameter int BLOCK_WORDS = 4,
   parameter int BEAT_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              inc,
   output logic [BEAT_W-1:0] beat,
   output logic              last
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;

   assign last = (beat_q == LAST_BEAT);
   assign beat = beat_q;

   // next beat: explicit wrap so non-power-of-two widths (BLOCK_WORDS=1) behave
   always_comb begin
      beat_d = beat_q;
      if (clear) begin
         beat_d = {BEAT_W{1'b0}};
      end else if (inc) begin
         if (last) begin
            beat_d = {BEAT_W{1'b0}};
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end else begin
         beat_d = beat_q;
      end
   end

   // beat register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q <= {BEAT_W{1'b0}};
      end else begin
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/l1_cache_ctrl_wb.sv
// Write-back / write-allocate L1 data cache controller with multi-word line bursts.
// Optional performance counters are built when L1_CACHE_PERF_EN is defined.
module l1_cache_ctrl_wb
   import l1_cache_pkg::*;
#(
   parameter int  TAG_W       = 22,
   parameter int  BLOCK_WORDS = 4,
   parameter int  CNT_W       = 32,
   localparam int BEAT_W      = beat_width(BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [TAG_W-1:0]  cpu_tag,
   output logic              cpu_ready,
   input  logic              sram_valid,
   input  logic              sram_dirty,
   input  logic [TAG_W-1:0]  sram_tag,
   output logic              sram_cs,
   output logic              sram_we,
   output logic              sram_fill,
   output logic              sram_set_dirty,
   output logic [BEAT_W-1:0] beat_idx,
   output logic              mem_cs,
   output logic              mem_we,
   output logic              mem_addr_sel,
   input  logic              mem_ack
`ifdef L1_CACHE_PERF_EN
   ,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt,
   output logic [CNT_W-1:0]  wb_cnt
`endif
);

   state_e            state_q;
   state_e            state_d;
   logic              hit_s;
   logic              bc_clear_s;
   logic              bc_inc_s;
   logic              bc_last_s;
   logic [BEAT_W-1:0] beat_s;

   assign hit_s    = sram_valid && (sram_tag == cpu_tag);
   assign beat_idx = beat_s;

   l1_beat_counter #(
      .BLOCK_WORDS (BLOCK_WORDS),
      .BEAT_W      (BEAT_W)
   ) u_beat_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (bc_clear_s),
      .inc   (bc_inc_s),
      .beat  (beat_s),
      .last  (bc_last_s)
   );

   // next-state and combinational outputs; everything stays low while rst is high
   always_comb begin
      state_d        = state_q;
      cpu_ready      = 1'b0;
      sram_cs        = 1'b0;
      sram_we        = 1'b0;
      sram_fill      = 1'b0;
      sram_set_dirty = 1'b0;
      mem_cs         = 1'b0;
      mem_we         = 1'b0;
      mem_addr_sel   = 1'b0;
      bc_clear_s     = 1'b0;
      bc_inc_s       = 1'b0;
      if (rst) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sram_cs = cpu_req;
               if (cpu_req) begin
                  state_d = ST_COMPARE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_COMPARE: begin
               sram_cs = 1'b1;
               if (!cpu_req) begin
                  state_d = ST_IDLE;
               end else if (hit_s) begin
                  cpu_ready      = 1'b1;
                  sram_we        = cpu_we;
                  sram_set_dirty = cpu_we;
                  state_d        = ST_IDLE;
               end else begin
                  bc_clear_s = 1'b1;
                  if (sram_valid && sram_dirty) begin
                     state_d = ST_WRITE_BACK;
                  end else begin
                     state_d = ST_ALLOCATE;
                  end
               end
            end
            ST_WRITE_BACK: begin
               mem_cs       = 1'b1;
               mem_we       = 1'b1;
               mem_addr_sel = 1'b1;
               if (mem_ack) begin
                  bc_inc_s = 1'b1;
                  if (bc_last_s) begin
                     state_d = ST_ALLOCATE;
                  end else begin
                     state_d = ST_WRITE_BACK;
                  end
               end else begin
                  state_d = ST_WRITE_BACK;
               end
            end
            ST_ALLOCATE: begin
               mem_cs = 1'b1;
               if (mem_ack) begin
                  sram_cs   = 1'b1;
                  sram_we   = 1'b1;
                  sram_fill = 1'b1;
                  bc_inc_s  = 1'b1;
                  // the re-compare after the last beat finds the new line and completes the access
                  if (bc_last_s) begin
                     state_d = ST_COMPARE;
                  end else begin
                     state_d = ST_ALLOCATE;
                  end
               end else begin
                  state_d = ST_ALLOCATE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef L1_CACHE_PERF_EN
   logic             recmp_q;
   logic             recmp_d;
   logic             hit_evt_s;
   logic             miss_evt_s;
   logic             wb_evt_s;
   logic [CNT_W-1:0] hit_cnt_q;
   logic [CNT_W-1:0] hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q;
   logic [CNT_W-1:0] miss_cnt_d;
   logic [CNT_W-1:0] wb_cnt_q;
   logic [CNT_W-1:0] wb_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}})) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   // recmp marks the compare that follows a refill so its completion is not counted as a hit
   always_comb begin
      hit_evt_s  = (state_q == ST_COMPARE) && cpu_ready && !recmp_q;
      miss_evt_s = (state_q == ST_COMPARE) &&
                   ((state_d == ST_ALLOCATE) || (state_d == ST_WRITE_BACK));
      wb_evt_s   = (state_q == ST_COMPARE) && (state_d == ST_WRITE_BACK);
      if (state_d == ST_COMPARE) begin
         if (state_q == ST_ALLOCATE) begin
            recmp_d = 1'b1;
         end else begin
            recmp_d = recmp_q;
         end
      end else begin
         recmp_d = 1'b0;
      end
      hit_cnt_d  = sat_inc(hit_cnt_q, hit_evt_s);
      miss_cnt_d = sat_inc(miss_cnt_q, miss_evt_s);
      wb_cnt_d   = sat_inc(wb_cnt_q, wb_evt_s);
   end

   // counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         recmp_q    <= 1'b0;
         hit_cnt_q  <= {CNT_W{1'b0}};
         miss_cnt_q <= {CNT_W{1'b0}};
         wb_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         recmp_q    <= recmp_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
   assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_l1_cache_ctrl_wb.sv
// Self-checking bench for l1_cache_ctrl_wb: directed and random accesses against a line-level cache model.
module tb_l1_cache_ctrl_wb;

   localparam int TW = 22;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, sram_valid, sram_dirty, mem_ack;
   logic [TW-1:0] cpu_tag, sram_tag;
   logic          cpu_ready, sram_cs, sram_we, sram_fill, sram_set_dirty;
   logic [1:0]    beat_idx;
   logic          mem_cs, mem_we, mem_addr_sel;
   logic          cpu_req1, mem_ack1;
   logic          cpu_ready1, sram_cs1, sram_we1, sram_fill1, sram_set_dirty1;
   logic [0:0]    beat_idx1;
   logic          mem_cs1, mem_we1, mem_addr_sel1;
`ifdef L1_CACHE_PERF_EN
   logic [31:0]   hit_cnt, miss_cnt, wb_cnt, hit_cnt1, miss_cnt1, wb_cnt1;
`endif

   int            compared = 0;
   int            mismatched = 0;
   logic          line_v, line_d;
   logic [TW-1:0] line_t;
   int            exp_hit, exp_miss, exp_wb;
   logic [TW-1:0] tags [3];

   always #5 clk = ~clk;

   l1_cache_ctrl_wb #(.TAG_W(TW), .BLOCK_WORDS(NW), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_tag(cpu_tag),
      .cpu_ready(cpu_ready), .sram_valid(sram_valid), .sram_dirty(sram_dirty),
      .sram_tag(sram_tag), .sram_cs(sram_cs), .sram_we(sram_we), .sram_fill(sram_fill),
      .sram_set_dirty(sram_set_dirty), .beat_idx(beat_idx), .mem_cs(mem_cs), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .mem_ack(mem_ack)
`ifdef L1_CACHE_PERF_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
   );

   l1_cache_ctrl_wb #(.TAG_W(TW), .BLOCK_WORDS(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst), .cpu_req(cpu_req1), .cpu_we(cpu_we), .cpu_tag(cpu_tag),
      .cpu_ready(cpu_ready1), .sram_valid(sram_valid), .sram_dirty(sram_dirty),
      .sram_tag(sram_tag), .sram_cs(sram_cs1), .sram_we(sram_we1), .sram_fill(sram_fill1),
      .sram_set_dirty(sram_set_dirty1), .beat_idx(beat_idx1), .mem_cs(mem_cs1), .mem_we(mem_we1),
      .mem_addr_sel(mem_addr_sel1), .mem_ack(mem_ack1)
`ifdef L1_CACHE_PERF_EN
      , .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1), .wb_cnt(wb_cnt1)
`endif
   );

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
      end
   endtask

   task automatic chk_outs(input string t, input logic rdy, input logic scs, input logic swe,
                           input logic sfill, input logic sdirty, input logic [1:0] bi,
                           input logic mcs, input logic mwe, input logic msel);
      chk({t, ".cpu_ready"}, cpu_ready, rdy);
      chk({t, ".sram_cs"}, sram_cs, scs);
      chk({t, ".sram_we"}, sram_we, swe);
      chk({t, ".sram_fill"}, sram_fill, sfill);
      chk({t, ".sram_set_dirty"}, sram_set_dirty, sdirty);
      chk({t, ".beat_idx"}, beat_idx, bi);
      chk({t, ".mem_cs"}, mem_cs, mcs);
      chk({t, ".mem_we"}, mem_we, mwe);
      chk({t, ".mem_addr_sel"}, mem_addr_sel, msel);
   endtask

   task automatic chk_perf(input string t);
`ifdef L1_CACHE_PERF_EN
      chk({t, ".hit_cnt"}, hit_cnt, exp_hit);
      chk({t, ".miss_cnt"}, miss_cnt, exp_miss);
      chk({t, ".wb_cnt"}, wb_cnt, exp_wb);
`else
      chk({t, ".beat_idle"}, beat_idx, 2'd0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sram();
      sram_valid = line_v;
      sram_dirty = line_d;
      sram_tag   = line_t;
   endtask

   // One CPU access; the expected cycle sequence follows from the line model.
   // abort_beat >= 0 pulses rst during that refill beat instead of finishing.
   task automatic access(input logic we, input logic [TW-1:0] tag, input int abort_beat);
      logic hit, dmiss, ack;
      int   stall;
      hit   = line_v && (line_t == tag);
      dmiss = !hit && line_v && line_d;
      cpu_we  = we;
      cpu_tag = tag;
      cpu_req = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      drive_sram();
      #1;
      chk_outs("idle_req", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      mem_ack = 1'($urandom_range(0, 1));
      drive_sram();
      #1;
      if (hit) begin
         chk_outs("hit", 1'b1, 1'b1, we, 1'b0, we, 2'd0, 1'b0, 1'b0, 1'b0);
         exp_hit++;
         if (we) line_d = 1'b1;
      end else begin
         chk_outs("miss_cmp", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
         exp_miss++;
         if (dmiss) exp_wb++;
         for (int ph = (dmiss ? 0 : 1); ph < 2; ph++) begin
            for (int k = 0; k < NW; k++) begin
               stall = int'($urandom_range(0, 2));
               for (int s = 0; s <= stall; s++) begin
                  tick();
                  ack     = (s == stall);
                  mem_ack = ack;
                  drive_sram();
                  #1;
                  chk_outs((ph == 0) ? "wb_beat" : "fill_beat", 1'b0, (ph == 1) && ack,
                           (ph == 1) && ack, (ph == 1) && ack, 1'b0, k[1:0], 1'b1,
                           ph == 0, ph == 0);
                  if ((ph == 1) && (k == abort_beat) && (s == 0)) begin
                     #1 rst = 1'b1;
                     #1;
                     chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
                     tick();
                     chk_outs("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
                     rst     = 1'b0;
                     cpu_req = 1'b0;
                     mem_ack = 1'b0;
                     line_v  = 1'b0;
                     line_d  = 1'b0;
                     exp_hit = 0;
                     exp_miss = 0;
                     exp_wb  = 0;
                     drive_sram();
                     #1;
                     chk_outs("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
                     chk_perf("rst_rel");
                     return;
                  end
                  if ((ph == 1) && ack) begin
                     line_v = 1'b1;
                     line_t = tag;
                     line_d = 1'b0;
                  end
               end
            end
         end
         tick();
         mem_ack = 1'($urandom_range(0, 1));
         drive_sram();
         #1;
         chk_outs("recmp", 1'b1, 1'b1, we, 1'b0, we, 2'd0, 1'b0, 1'b0, 1'b0);
         if (we) line_d = 1'b1;
      end
      tick();
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      drive_sram();
      #1;
      chk_outs("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk_perf("done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tags[0] = 22'h0A5A5A;
      tags[1] = 22'h13C3C3;
      tags[2] = 22'h2F0F0F;
      rst = 1'b1;
      cpu_req = 1'b1;
      cpu_req1 = 1'b1;
      cpu_we = 1'b0;
      cpu_tag = tags[0];
      mem_ack = 1'b1;
      mem_ack1 = 1'b0;
      line_v = 1'b0;
      line_d = 1'b0;
      line_t = '0;
      exp_hit = 0;
      exp_miss = 0;
      exp_wb = 0;
      drive_sram();
      tick();
      tick();
      chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("reset.sram_cs1", sram_cs1, 1'b0);
      cpu_req = 1'b0;
      cpu_req1 = 1'b0;
      mem_ack = 1'b0;
      rst = 1'b0;
      #1;
      chk_perf("reset");

      // directed: store clean miss, load hit, store hit, dirty load miss
      access(1'b1, tags[0], -1);
      access(1'b0, tags[0], -1);
      access(1'b1, tags[0], -1);
      access(1'b0, tags[1], -1);

      // spurious acks while idle start nothing
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_ack = 1'b1;
         #1;
         chk_outs("idle_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      end
      mem_ack = 1'b0;

      // reset during refill beat 2, then a dirty miss from fresh counters
      tick();
      line_v = 1'b0;
      access(1'b0, tags[2], 2);
      tick();
      line_v = 1'b1;
      line_d = 1'b1;
      line_t = tags[2];
      access(1'b0, tags[0], -1);

      for (int n = 0; n < 40; n++) begin
         access(1'($urandom_range(0, 1)), tags[$urandom_range(0, 2)], -1);
      end

      // single-word line instance: one ack per phase
      tick();
      sram_valid = 1'b0;
      sram_dirty = 1'b0;
      cpu_tag = tags[1];
      cpu_we = 1'b0;
      mem_ack1 = 1'b1;
      #1;
      chk("bw1.idle_ack_mem_cs", mem_cs1, 1'b0);
      tick();
      cpu_req1 = 1'b1;
      mem_ack1 = 1'b0;
      #1;
      chk("bw1.idle_sram_cs", sram_cs1, 1'b1);
      tick();
      mem_ack1 = 1'b1;
      #1;
      chk("bw1.cmp_ready", cpu_ready1, 1'b0);
      chk("bw1.cmp_mem_cs", mem_cs1, 1'b0);
      tick();
      mem_ack1 = 1'b0;
      #1;
      chk("bw1.stall_mem_cs", mem_cs1, 1'b1);
      chk("bw1.stall_fill", sram_fill1, 1'b0);
      chk("bw1.stall_mem_we", mem_we1, 1'b0);
      tick();
      mem_ack1 = 1'b1;
      #1;
      chk("bw1.fill", sram_fill1, 1'b1);
      chk("bw1.fill_we", sram_we1, 1'b1);
      chk("bw1.fill_beat", beat_idx1, 1'b0);
      tick();
      mem_ack1 = 1'b0;
      sram_valid = 1'b1;
      sram_tag = tags[1];
      #1;
      chk("bw1.recmp_ready", cpu_ready1, 1'b1);
      tick();
      cpu_req1 = 1'b0;
      #1;
      chk("bw1.done_ready", cpu_ready1, 1'b0);
      chk("bw1.done_mem_cs", mem_cs1, 1'b0);
`ifdef L1_CACHE_PERF_EN
      chk("bw1.miss_cnt", miss_cnt1, 32'd1);
      chk("bw1.hit_cnt", hit_cnt1, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
